// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen, colour and source-index constants for the draw path
//
// Purpose : constants and types shared by draw_scheduler and box_scan.
// Ports   : none (package).
package game_pkg;

   localparam int SCREEN_W     = 160;
   localparam int SCREEN_H     = 120;
   localparam int PLAYER_WIDTH = 3;
   localparam int BULLET_WIDTH = 1;

   localparam logic [2:0] COL_PLAYER = 3'b010;
   localparam logic [2:0] COL_BULLET = 3'b110;
   localparam logic [2:0] COL_ENEMY  = 3'b100;
   localparam logic [2:0] COL_BG     = 3'b000;

   localparam int SRC_PLAYER = 0;
   localparam int SRC_BULLET = 1;
   localparam int SRC_ENEMY0 = 2;

   // Top-left corner plus side length of an on-screen square; w = 0 means nothing drawn.
   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [3:0] w;
   } square_t;

endpackage

// File: rtl/draw_scheduler_if.sv
// rtl/draw_scheduler_if.sv - pixel-write bus between draw_scheduler and the VGA adapter
//
// Purpose : one registered pixel write per cycle.
// Signals : vga_x[7:0], vga_y[6:0], vga_colour[2:0], plot (write strobe).
// Modports: master drives the pixel bus, slave (VGA adapter) receives it.
interface draw_scheduler_if;

   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       plot;

   modport master (output vga_x, vga_y, vga_colour, plot);
   modport slave  (input  vga_x, vga_y, vga_colour, plot);

endinterface

// File: rtl/box_scan.sv
// rtl/box_scan.sv - walks a w x w square one pixel per cycle, column offset inner
//
// Purpose : shared square scanner for the erase and draw phases.
// Ports   : clk, resetn (sync, active-low), abort (sync clear),
//           load + sq (origin/width, starts a scan; w = 0 starts nothing),
//           active (a pixel is presented this cycle), px[8:0]/py[7:0]
//           (unclipped pixel), done (high with the last pixel).
module box_scan
   import game_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       abort,
   input  logic       load,
   input  square_t    sq,
   output logic       active,
   output logic [8:0] px,
   output logic [7:0] py,
   output logic       done
);

   square_t    sq_r;
   logic [3:0] col;
   logic [3:0] row;
   logic       col_last;
   logic       row_last;

   assign col_last = (col == sq_r.w - 4'd1);
   assign row_last = (row == sq_r.w - 4'd1);

   // Extra bit on each sum so squares hanging off the right/bottom edge can be clipped.
   assign px   = {1'b0, sq_r.x} + {5'd0, col};
   assign py   = {1'b0, sq_r.y} + {4'd0, row};
   assign done = active && col_last && row_last;

   always_ff @(posedge clk) begin
      if (!resetn || abort) begin
         sq_r   <= '0;
         col    <= '0;
         row    <= '0;
         active <= 1'b0;
      end else if (load) begin
         // Load wins over stepping so a new scan can start on the last pixel of the previous one.
         sq_r   <= sq;
         col    <= '0;
         row    <= '0;
         active <= (sq.w != 4'd0);
      end else if (active) begin
         if (col_last && row_last) begin
            active <= 1'b0;
         end else if (col_last) begin
            col <= '0;
            row <= row + 4'd1;
         end else begin
            col <= col + 4'd1;
         end
      end
   end

endmodule

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - shares the VGA pixel port among player, bullet and enemies
//
// Purpose : blanks the screen after reset/load_level, then on each move pulse
//           erases a source's old square and draws it at its current position.
// Ports   : clk, resetn (sync, active-low), load_level (restart + clear),
//           player_move/x/y, bullet_move/x/y, enemy_move/x/y/w (packed per enemy),
//           vga (pixel bus master: vga_x, vga_y, vga_colour, plot), busy (not IDLE).
module draw_scheduler
   import game_pkg::*;
#(
   parameter int         N_ENEMY    = 4,
   parameter logic [2:0] PLAYER_COL = COL_PLAYER,
   parameter logic [2:0] BULLET_COL = COL_BULLET,
   parameter logic [2:0] ENEMY_COL  = COL_ENEMY,
   parameter logic [2:0] BG_COL     = COL_BG
)(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 load_level,
   input  logic                 player_move,
   input  logic [7:0]           player_x,
   input  logic [6:0]           player_y,
   input  logic                 bullet_move,
   input  logic [7:0]           bullet_x,
   input  logic [6:0]           bullet_y,
   input  logic [N_ENEMY-1:0]   enemy_move,
   input  logic [8*N_ENEMY-1:0] enemy_x,
   input  logic [7*N_ENEMY-1:0] enemy_y,
   input  logic [4*N_ENEMY-1:0] enemy_w,
   draw_scheduler_if.master     vga,
   output logic                 busy
);

   localparam int S  = N_ENEMY + 2;
   localparam int IW = $clog2(S);

   localparam logic [2:0] ST_CLEAR = 3'd0;
   localparam logic [2:0] ST_IDLE  = 3'd1;
   localparam logic [2:0] ST_PICK  = 3'd2;
   localparam logic [2:0] ST_ERASE = 3'd3;
   localparam logic [2:0] ST_DRAW  = 3'd4;

   logic [2:0]    state;
   logic [IW-1:0] ptr, sel, next_sel;
   logic [IW:0]   rr_sum;
   logic          found;
   logic [S-1:0]  pending, move_vec, clr_mask;
   square_t       src_sq [S];
   square_t       old_sq [S];
   square_t       snap;
   square_t       box_sq;
   logic          box_load, box_active, box_done;
   logic [8:0]    box_px;
   logic [7:0]    box_py;
   logic [2:0]    cur_col;
   logic [7:0]    cx;
   logic [6:0]    cy;

   assign busy = (state != ST_IDLE);

   always_comb begin
      move_vec = {enemy_move, bullet_move, player_move};
      src_sq[SRC_PLAYER] = '{x: player_x, y: player_y, w: 4'(PLAYER_WIDTH)};
      src_sq[SRC_BULLET] = '{x: bullet_x, y: bullet_y, w: 4'(BULLET_WIDTH)};
      for (int i = 0; i < N_ENEMY; i++) begin
         src_sq[SRC_ENEMY0 + i] = '{x: enemy_x[8*i +: 8], y: enemy_y[7*i +: 7], w: enemy_w[4*i +: 4]};
      end
   end

   assign cur_col = (sel == IW'(SRC_PLAYER)) ? PLAYER_COL :
                    (sel == IW'(SRC_BULLET)) ? BULLET_COL : ENEMY_COL;

   // Round-robin: first pending source after the one served last, wrapping at S.
   always_comb begin
      next_sel = ptr;
      found    = 1'b0;
      rr_sum   = '0;
      for (int k = 1; k <= S; k++) begin
         rr_sum = {1'b0, ptr} + (IW+1)'(k);
         if (rr_sum >= (IW+1)'(S)) rr_sum = rr_sum - (IW+1)'(S);
         if (!found && pending[rr_sum[IW-1:0]]) begin
            next_sel = rr_sum[IW-1:0];
            found    = 1'b1;
         end
      end
   end

   assign clr_mask = (state == ST_PICK) ? (S'(1) << sel) : '0;

   // PICK starts the erase (or the draw when nothing is on screen yet);
   // the last erase pixel chains straight into the draw of the snapshot.
   always_comb begin
      box_load = 1'b0;
      box_sq   = snap;
      if (state == ST_PICK) begin
         box_load = 1'b1;
         box_sq   = (old_sq[sel].w != 4'd0) ? old_sq[sel] : src_sq[sel];
      end else if (state == ST_ERASE && box_done && snap.w != 4'd0) begin
         box_load = 1'b1;
      end
   end

   box_scan u_box (
      .clk    (clk),
      .resetn (resetn),
      .abort  (load_level),
      .load   (box_load),
      .sq     (box_sq),
      .active (box_active),
      .px     (box_px),
      .py     (box_py),
      .done   (box_done)
   );

   always_ff @(posedge clk) begin
      if (!resetn || load_level) begin
         state   <= ST_CLEAR;
         cx      <= '0;
         cy      <= '0;
         pending <= '0;
         ptr     <= IW'(S-1);
         sel     <= '0;
         snap    <= '0;
         for (int i = 0; i < S; i++) old_sq[i] <= '0;
      end else begin
         // A move pulse in the same cycle as the PICK clear keeps its bit set.
         pending <= (pending & ~clr_mask) | move_vec;
         case (state)
            ST_CLEAR: begin
               if (cx == 8'(SCREEN_W-1)) begin
                  cx <= '0;
                  if (cy == 7'(SCREEN_H-1)) begin
                     cy      <= '0;
                     state   <= ST_IDLE;
                     pending <= '1;
                     for (int i = 0; i < S; i++) old_sq[i] <= '0;
                  end else begin
                     cy <= cy + 7'd1;
                  end
               end else begin
                  cx <= cx + 8'd1;
               end
            end
            ST_IDLE: begin
               if (|pending) begin
                  sel   <= next_sel;
                  ptr   <= next_sel;
                  state <= ST_PICK;
               end
            end
            ST_PICK: begin
               snap <= src_sq[sel];
               if (old_sq[sel].w != 4'd0) begin
                  state <= ST_ERASE;
               end else if (src_sq[sel].w != 4'd0) begin
                  state <= ST_DRAW;
               end else begin
                  old_sq[sel] <= src_sq[sel];
                  state       <= ST_IDLE;
               end
            end
            ST_ERASE: begin
               if (box_done) begin
                  if (snap.w != 4'd0) begin
                     state <= ST_DRAW;
                  end else begin
                     old_sq[sel] <= snap;
                     state       <= ST_IDLE;
                  end
               end
            end
            ST_DRAW: begin
               if (box_done) begin
                  old_sq[sel] <= snap;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

   // Registered pixel bus; off-screen pixels keep their cycle but do not strobe.
   always_ff @(posedge clk) begin
      if (!resetn || load_level) begin
         vga.vga_x      <= '0;
         vga.vga_y      <= '0;
         vga.vga_colour <= '0;
         vga.plot       <= 1'b0;
      end else begin
         vga.plot <= 1'b0;
         if (state == ST_CLEAR) begin
            vga.vga_x      <= cx;
            vga.vga_y      <= cy;
            vga.vga_colour <= BG_COL;
            vga.plot       <= 1'b1;
         end else if ((state == ST_ERASE || state == ST_DRAW) && box_active) begin
            vga.vga_x      <= box_px[7:0];
            vga.vga_y      <= box_py[6:0];
            vga.vga_colour <= (state == ST_ERASE) ? BG_COL : cur_col;
            vga.plot       <= (box_px < 9'(SCREEN_W)) && (box_py < 8'(SCREEN_H));
         end
      end
   end

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Owns the single pixel-write port of the VGA adapter and shares it among all moving objects: player, bullet and `N_ENEMY` enemies. On each object's `move` pulse it erases the object's previously drawn square and redraws it at its current coordinates. On reset or `load_level` it blanks the whole 160×120 screen first. It sits between the object controllers and the VGA adapter's `x/y/colour/plot` inputs.

## Interface
- `N_ENEMY`, 4: number of enemy sources
- `PLAYER_COL`, 3'b010: player colour
- `BULLET_COL`, 3'b110: bullet colour
- `ENEMY_COL`, 3'b100: enemy colour
- `BG_COL`, 3'b000: background/erase colour

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset; synchronous, active-low
- `load_level`  in  1  restart: abort current work, clear screen
- `player_move`  in  1  one-cycle move pulse
- `player_x`/`player_y`  in  8/7  player top-left
- `bullet_move`, `bullet_x`, `bullet_y`  in  1/8/7  bullet equivalents
- `enemy_move`  in  N_ENEMY  per-enemy move pulses
- `enemy_x`  in  8·N_ENEMY  packed; enemy i at [8i+7:8i]
- `enemy_y`  in  7·N_ENEMY  packed
- `enemy_w`  in  4·N_ENEMY  packed square widths; 0 = dead
- `vga_x`  out  8  pixel x
- `vga_y`  out  7  pixel y
- `vga_colour`  out  3  pixel colour
- `plot`  out  1  write strobe
- `busy`  out  1  high in any state other than IDLE

## Operation
- Source index: 0 = player (width 3), 1 = bullet (width 1), 2+i = enemy i (width `enemy_w[i]`). S = N_ENEMY + 2.
- `pending[S]` is sticky and set by the source's move pulse. If a set and a service-clear hit the same cycle, the set wins.
- Per-source stored state: `old_x`, `old_y`, `old_w`. All `old_w` = 0 after reset or clear.
- FSM states: CLEAR, IDLE, PICK, ERASE, DRAW.
  - CLEAR: scans x 0..159 (inner loop), y 0..119, writing `BG_COL`. On exit sets all `pending` bits and resets all `old_w` to 0, then goes to IDLE.
  - IDLE: if any `pending`, selects a source round-robin, starting from last served + 1. Goes to PICK.
  - PICK: snapshots the selected source's current x, y, w and clears its pending bit. Goes to ERASE, or directly to DRAW if `old_w` = 0.
  - ERASE: scans the `old_w`×`old_w` square at `old_x`/`old_y` in `BG_COL`, then goes to DRAW.
  - DRAW: scans the snapshot square in the source colour. It is skipped if snapshot w = 0. Afterwards `old_*` ← snapshot and the FSM returns to IDLE.
- Scan order: column offset inner, row offset outer; one pixel per cycle.
- Clipping: a pixel with x ≥ 160 or y ≥ 120 still takes its cycle but is emitted with `plot` = 0.
- Arithmetic: coordinate + offset is computed 9 bits wide for x and 8 bits wide for y before the clip compare.
- Dead enemy (w = 0 at service time): old square is erased, nothing is drawn.

## Timing
- Reset: `vga_x` = 0, `vga_y` = 0, `vga_colour` = 0, `plot` = 0, `pending` = 0, round-robin pointer = S−1, state = CLEAR. `busy` = 1.
- `vga_*` and `plot` are registered: a pixel generated by a state in cycle t appears on the outputs in t+1.
- Service cost is 1 (PICK) + old_w² + new_w² cycles, then at least 1 IDLE cycle. Example: player move = 1 + 9 + 9 cycles.
- Latency: pending seen in IDLE at cycle t → PICK at t+1 → first `plot` at t+3.
- Full clear takes 19200 cycles. `plot` is high on every one of them.
- `load_level` or `resetn` low in any state, including mid-ERASE/DRAW/CLEAR, aborts work next edge and restarts CLEAR from (0,0); `pending` is cleared.
- Move pulses arriving during CLEAR are absorbed, because the end of CLEAR sets every `pending` bit anyway.
- Coordinates changing after PICK do not affect the square in progress.

## Structure
- Shared package `game_pkg` holds: SCREEN_W = 160, SCREEN_H = 120, PLAYER_WIDTH = 3, colour constants, source-index constants (SRC_PLAYER, SRC_BULLET, SRC_ENEMY0).
- Sub-module `box_scan`: loads origin and width, emits offset pixels one per cycle, and pulses `done` on the last pixel. It is reused for ERASE and DRAW. CLEAR uses its own 160×120 counter.
- Round-robin select is inline in `draw_scheduler`.

## Test plan
- Reset, no moves → `plot` high for exactly 19200 cycles covering (0,0)..(159,119) in BG; then one 9-pixel player draw at (80,115) and one bullet draw. Enemies draw only if `enemy_w` ≠ 0.
- Player at (80,115) pulses move, then x = 81 → 9 BG pixels at x 80..82, y 115..117, then 9 `PLAYER_COL` pixels at x 81..83; `busy` low afterwards.
- `player_move`, `bullet_move` and `enemy_move[0]` pulse in the same cycle → services follow the round-robin order from the pointer. Each source is served exactly once, and no pixel streams interleave.
- Enemy 1 with w = 4 at (158,118) → pixels at x ≥ 160 or y ≥ 120 have `plot` = 0; service still takes 1 + 16 + 16 cycles.
- Enemy 2 `enemy_w` drops to 0, then move → erase of the old square only, no draw; `old_w` = 0 after.
- `load_level` asserted during a DRAW → next cycle CLEAR restarts at (0,0), `pending` = 0, and the full 19200-pixel clear completes.
